// File: rtl/stall_ctrl_pkg.sv
// Shared stall vectors and sequencer state encoding for stall_ctrl.
// Optional perf counters are enabled by defining STALL_PERF_CNT_EN.
package stall_ctrl_pkg;

  localparam logic [5:0] STALL_NONE    = 6'b000000;
  localparam logic [5:0] STALL_FROM_ID = 6'b000111;
  localparam logic [5:0] STALL_FROM_EX = 6'b001111;

  typedef enum logic {
    RUN     = 1'b0,
    MC_HOLD = 1'b1
  } state_t;

endpackage

// File: rtl/stall_ctrl_mc_hold_counter.sv
// Down-counter for EX multi-cycle holds: load, decrement to zero, zero flag.
module stall_ctrl_mc_hold_counter #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero
);

  logic [CNT_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
    end else if (load) begin
      cnt_reg <= load_val;
    end else if (dec && (cnt_reg != '0)) begin
      cnt_reg <= cnt_reg - 1'b1;
    end
  end

  assign cnt  = cnt_reg;
  assign zero = (cnt_reg == '0);

endmodule

// File: rtl/stall_ctrl.sv
// Pipeline stall sequencer: EX/ID request merge, load-use detection, multi-cycle hold FSM.
// Define STALL_PERF_CNT_EN to build the saturating stall/load-use performance counters.
module stall_ctrl
  import stall_ctrl_pkg::*;
#(
  parameter int CNT_W  = 6,
  parameter int REG_AW = 5,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq_from_id,
  input  logic              stallreq_from_ex,
  input  logic              ex_is_load,
  input  logic [REG_AW-1:0] ex_wd,
  input  logic              id_reg1_read,
  input  logic [REG_AW-1:0] id_reg1_addr,
  input  logic              id_reg2_read,
  input  logic [REG_AW-1:0] id_reg2_addr,
  input  logic              ex_mc_start,
  input  logic [CNT_W-1:0]  ex_mc_len,
  output logic [5:0]        stall,
  output logic              load_use_o,
  output logic              mc_busy_o,
  output logic [PERF_W-1:0] perf_stall_cyc_o,
  output logic [PERF_W-1:0] perf_load_use_o
);

  state_t           state_reg, state_next;
  logic             cnt_load, cnt_dec, cnt_zero;
  logic [CNT_W-1:0] cnt;
  logic             mc_start_ok, mc_active, lu_raw;
  logic [5:0]       stall_sel;

  stall_ctrl_mc_hold_counter #(.CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .load_val (ex_mc_len - CNT_W'(2)),
    .dec      (cnt_dec),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  // A start is only honoured from RUN and only for a non-zero length.
  assign mc_start_ok = (state_reg == RUN) && ex_mc_start && (ex_mc_len != '0);
  assign mc_active   = mc_start_ok || (state_reg == MC_HOLD);

  assign lu_raw = ex_is_load && (ex_wd != '0) &&
                  ((id_reg1_read && (id_reg1_addr == ex_wd)) ||
                   (id_reg2_read && (id_reg2_addr == ex_wd)));

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= RUN;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_load   = 1'b0;
    cnt_dec    = 1'b0;
    case (state_reg)
      RUN: begin
        // len==1 is fully covered by the start cycle, so only len>=2 enters MC_HOLD.
        if (mc_start_ok && (ex_mc_len >= CNT_W'(2))) begin
          state_next = MC_HOLD;
          cnt_load   = 1'b1;
        end
      end
      MC_HOLD: begin
        if (cnt_zero) begin
          state_next = RUN;
        end else begin
          cnt_dec = 1'b1;
        end
      end
      default: state_next = RUN;
    endcase
  end

  always_comb begin
    stall_sel = STALL_NONE;
    if (mc_active || stallreq_from_ex) begin
      stall_sel = STALL_FROM_EX;
    end else if (lu_raw || stallreq_from_id) begin
      stall_sel = STALL_FROM_ID;
    end
  end

  assign stall      = rst ? STALL_NONE : stall_sel;
  assign load_use_o = !rst && lu_raw && (stall_sel == STALL_FROM_ID);
  assign mc_busy_o  = !rst && (state_reg == MC_HOLD);

`ifdef STALL_PERF_CNT_EN
  logic [PERF_W-1:0] perf_stall_reg, perf_lu_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_stall_reg <= '0;
      perf_lu_reg    <= '0;
    end else begin
      if ((stall != STALL_NONE) && (perf_stall_reg != '1)) begin
        perf_stall_reg <= perf_stall_reg + 1'b1;
      end
      if (load_use_o && (perf_lu_reg != '1)) begin
        perf_lu_reg <= perf_lu_reg + 1'b1;
      end
    end
  end

  assign perf_stall_cyc_o = perf_stall_reg;
  assign perf_load_use_o  = perf_lu_reg;
`else
  assign perf_stall_cyc_o = '0;
  assign perf_load_use_o  = '0;
`endif

endmodule

// File: tb/tb_stall_ctrl.sv
// Self-checking bench for stall_ctrl: directed scenarios plus randomized traffic vs. a hold-count model.
module tb_stall_ctrl;

  localparam logic [5:0] S_NONE = 6'b000000;
  localparam logic [5:0] S_ID   = 6'b000111;
  localparam logic [5:0] S_EX   = 6'b001111;

  logic        clk = 1'b0;
  logic        rst;
  logic        stallreq_from_id, stallreq_from_ex, ex_is_load;
  logic [4:0]  ex_wd, id_reg1_addr, id_reg2_addr;
  logic        id_reg1_read, id_reg2_read, ex_mc_start;
  logic [5:0]  ex_mc_len;
  logic [5:0]  stall;
  logic        load_use_o, mc_busy_o;
  logic [31:0] perf_stall_cyc_o, perf_load_use_o;

  int checks = 0;
  int errors = 0;

  // Model: number of hold cycles still owed after the current one, plus perf totals.
  int          rem;
  logic [31:0] m_pc, m_pl;
  logic [5:0]  exp_stall;
  logic        exp_lu, exp_busy;

  always #5 clk = ~clk;

  stall_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .stallreq_from_id (stallreq_from_id),
    .stallreq_from_ex (stallreq_from_ex),
    .ex_is_load       (ex_is_load),
    .ex_wd            (ex_wd),
    .id_reg1_read     (id_reg1_read),
    .id_reg1_addr     (id_reg1_addr),
    .id_reg2_read     (id_reg2_read),
    .id_reg2_addr     (id_reg2_addr),
    .ex_mc_start      (ex_mc_start),
    .ex_mc_len        (ex_mc_len),
    .stall            (stall),
    .load_use_o       (load_use_o),
    .mc_busy_o        (mc_busy_o),
    .perf_stall_cyc_o (perf_stall_cyc_o),
    .perf_load_use_o  (perf_load_use_o)
  );

  task automatic clear_inputs();
    stallreq_from_id = 0; stallreq_from_ex = 0; ex_is_load = 0; ex_wd = 0;
    id_reg1_read = 0; id_reg1_addr = 0; id_reg2_read = 0; id_reg2_addr = 0;
    ex_mc_start = 0; ex_mc_len = 0;
  endtask

  // Expected outputs for the current inputs, derived from the rules directly.
  task automatic eval();
    logic hazard, hold;
    hazard = ex_is_load && ex_wd != 0 &&
             ((id_reg1_read && id_reg1_addr == ex_wd) || (id_reg2_read && id_reg2_addr == ex_wd));
    hold = (rem > 0) || (ex_mc_start && ex_mc_len != 0);
    if (rst) begin
      exp_stall = S_NONE; exp_lu = 0; exp_busy = 0;
    end else begin
      exp_stall = (hold || stallreq_from_ex) ? S_EX : ((hazard || stallreq_from_id) ? S_ID : S_NONE);
      exp_lu    = hazard && exp_stall == S_ID;
      exp_busy  = rem > 0;
    end
  endtask

  task automatic tick();
    eval();
    @(posedge clk);
    if (rst) begin
      rem = 0; m_pc = 0; m_pl = 0;
    end else begin
      if (exp_stall != S_NONE && m_pc != 32'hFFFF_FFFF) m_pc = m_pc + 1;
      if (exp_lu && m_pl != 32'hFFFF_FFFF) m_pl = m_pl + 1;
      if (rem > 0) rem = rem - 1;
      else if (ex_mc_start && ex_mc_len != 0) rem = int'(ex_mc_len) - 1;
    end
    #1;
  endtask

  task automatic do_reset();
    clear_inputs();
    rst = 1;
    tick(); tick();
    rst = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst = 1;
    stallreq_from_ex = 1; ex_mc_start = 1; ex_mc_len = 6'd4;
    @(negedge clk);
    checks++; if (stall !== S_NONE || load_use_o !== 1'b0 || mc_busy_o !== 1'b0) begin
      errors++; $display("FAIL reset_outputs stall=%b lu=%b busy=%b required 000000/0/0", stall, load_use_o, mc_busy_o);
    end
    tick();
    clear_inputs();
    tick();
    @(negedge clk);
    checks++; if (perf_stall_cyc_o !== 32'd0 || perf_load_use_o !== 32'd0) begin
      errors++; $display("FAIL reset_perf got %0d/%0d required 0/0", perf_stall_cyc_o, perf_load_use_o);
    end
    rst = 0;
    @(negedge clk);
    checks++; if (stall !== S_NONE || mc_busy_o !== 1'b0) begin
      errors++; $display("FAIL reset_release stall=%b busy=%b required 000000/0", stall, mc_busy_o);
    end
    tick();
  endtask

  task automatic test_mc_hold();
    clear_inputs();
    for (int i = 0; i < 7; i++) begin
      ex_mc_start = (i == 0); ex_mc_len = (i == 0) ? 6'd5 : 6'd0;
      @(negedge clk);
      checks++; if (stall !== ((i < 5) ? S_EX : S_NONE)) begin
        errors++; $display("FAIL mc5_stall cycle %0d got %b required %b", i, stall, (i < 5) ? S_EX : S_NONE);
      end
      checks++; if (mc_busy_o !== (i >= 1 && i <= 4)) begin
        errors++; $display("FAIL mc5_busy cycle %0d got %b required %b", i, mc_busy_o, (i >= 1 && i <= 4));
      end
      tick();
    end
  endtask

  task automatic test_load_use();
    clear_inputs();
    ex_is_load = 1; ex_wd = 5'd8; id_reg2_read = 1; id_reg2_addr = 5'd8;
    @(negedge clk);
    checks++; if (stall !== S_ID || load_use_o !== 1'b1) begin
      errors++; $display("FAIL lu_hit stall=%b lu=%b required 000111/1", stall, load_use_o);
    end
    tick();
    ex_wd = 5'd0; id_reg2_addr = 5'd0;
    @(negedge clk);
    checks++; if (stall !== S_NONE || load_use_o !== 1'b0) begin
      errors++; $display("FAIL lu_r0 stall=%b lu=%b required 000000/0", stall, load_use_o);
    end
    tick();
    ex_wd = 5'd3; id_reg2_read = 0; id_reg1_read = 0; id_reg1_addr = 5'd3; id_reg2_addr = 5'd3;
    @(negedge clk);
    checks++; if (stall !== S_NONE || load_use_o !== 1'b0) begin
      errors++; $display("FAIL lu_noread stall=%b lu=%b required 000000/0", stall, load_use_o);
    end
    tick();
    id_reg1_read = 1;
    @(negedge clk);
    checks++; if (stall !== S_ID || load_use_o !== 1'b1) begin
      errors++; $display("FAIL lu_port1 stall=%b lu=%b required 000111/1", stall, load_use_o);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_ex_priority();
    clear_inputs();
    ex_is_load = 1; ex_wd = 5'd12; id_reg1_read = 1; id_reg1_addr = 5'd12; stallreq_from_ex = 1;
    @(negedge clk);
    checks++; if (stall !== S_EX || load_use_o !== 1'b0) begin
      errors++; $display("FAIL ex_over_lu stall=%b lu=%b required 001111/0", stall, load_use_o);
    end
    tick();
    stallreq_from_ex = 0; ex_mc_start = 1; ex_mc_len = 6'd3;
    @(negedge clk);
    checks++; if (stall !== S_EX || load_use_o !== 1'b0) begin
      errors++; $display("FAIL mc_over_lu stall=%b lu=%b required 001111/0", stall, load_use_o);
    end
    tick();
    ex_mc_start = 0;
    tick(); tick();
    ex_is_load = 0; stallreq_from_id = 1;
    @(negedge clk);
    checks++; if (stall !== S_ID || load_use_o !== 1'b0) begin
      errors++; $display("FAIL id_req stall=%b lu=%b required 000111/0", stall, load_use_o);
    end
    tick();
    clear_inputs();
  endtask

  task automatic test_len_edges();
    clear_inputs();
    ex_mc_start = 1; ex_mc_len = 6'd1;
    @(negedge clk);
    checks++; if (stall !== S_EX || mc_busy_o !== 1'b0) begin
      errors++; $display("FAIL len1_start stall=%b busy=%b required 001111/0", stall, mc_busy_o);
    end
    tick();
    clear_inputs();
    @(negedge clk);
    checks++; if (stall !== S_NONE || mc_busy_o !== 1'b0) begin
      errors++; $display("FAIL len1_after stall=%b busy=%b required 000000/0", stall, mc_busy_o);
    end
    tick();
    ex_mc_start = 1; ex_mc_len = 6'd0;
    @(negedge clk);
    checks++; if (stall !== S_NONE) begin
      errors++; $display("FAIL len0 stall=%b required 000000", stall);
    end
    tick();
    for (int i = 0; i < 5; i++) begin
      ex_mc_start = (i <= 1); ex_mc_len = (i == 0) ? 6'd3 : 6'd7;
      @(negedge clk);
      checks++; if (stall !== ((i < 3) ? S_EX : S_NONE)) begin
        errors++; $display("FAIL restart_ignored cycle %0d got %b required %b", i, stall, (i < 3) ? S_EX : S_NONE);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_reset_mid_hold();
    clear_inputs();
    ex_mc_start = 1; ex_mc_len = 6'd10;
    tick();
    clear_inputs();
    tick();
    rst = 1;
    @(negedge clk);
    checks++; if (stall !== S_NONE || mc_busy_o !== 1'b0) begin
      errors++; $display("FAIL rst_mid_hold stall=%b busy=%b required 000000/0", stall, mc_busy_o);
    end
    tick();
    rst = 0;
    @(negedge clk);
    checks++; if (stall !== S_NONE || mc_busy_o !== 1'b0) begin
      errors++; $display("FAIL rst_released stall=%b busy=%b required 000000/0", stall, mc_busy_o);
    end
    tick();
    for (int i = 0; i < 4; i++) begin
      ex_mc_start = (i == 0); ex_mc_len = 6'd2;
      @(negedge clk);
      checks++; if (stall !== ((i < 2) ? S_EX : S_NONE)) begin
        errors++; $display("FAIL len2_after_rst cycle %0d got %b required %b", i, stall, (i < 2) ? S_EX : S_NONE);
      end
      tick();
    end
    clear_inputs();
  endtask

  task automatic test_perf();
    do_reset();
    ex_mc_start = 1; ex_mc_len = 6'd5;
    tick();
    clear_inputs();
    for (int i = 0; i < 5; i++) tick();
    ex_is_load = 1; ex_wd = 5'd8; id_reg2_read = 1; id_reg2_addr = 5'd8;
    tick();
    clear_inputs();
    tick();
    @(negedge clk);
`ifdef STALL_PERF_CNT_EN
    checks++; if (perf_stall_cyc_o !== 32'd6 || perf_load_use_o !== 32'd1) begin
      errors++; $display("FAIL perf_scen got %0d/%0d required 6/1", perf_stall_cyc_o, perf_load_use_o);
    end
`else
    checks++; if (perf_stall_cyc_o !== 32'd0 || perf_load_use_o !== 32'd0) begin
      errors++; $display("FAIL perf_off got %0d/%0d required 0/0", perf_stall_cyc_o, perf_load_use_o);
    end
`endif
  endtask

  task automatic test_random();
    logic [31:0] ep_pc, ep_pl;
    for (int n = 0; n < 400; n++) begin
      rst              = ($urandom_range(0, 49) == 0);
      stallreq_from_id = ($urandom_range(0, 7) == 0);
      stallreq_from_ex = ($urandom_range(0, 9) == 0);
      ex_is_load       = $urandom_range(0, 1);
      ex_wd            = 5'($urandom_range(0, 3));
      id_reg1_read     = $urandom_range(0, 1);
      id_reg1_addr     = 5'($urandom_range(0, 3));
      id_reg2_read     = $urandom_range(0, 1);
      id_reg2_addr     = 5'($urandom_range(0, 3));
      ex_mc_start      = ($urandom_range(0, 5) == 0);
      ex_mc_len        = 6'($urandom_range(0, 8));
      eval();
`ifdef STALL_PERF_CNT_EN
      ep_pc = m_pc; ep_pl = m_pl;
`else
      ep_pc = 0; ep_pl = 0;
`endif
      @(negedge clk);
      checks++; if (stall !== exp_stall || load_use_o !== exp_lu || mc_busy_o !== exp_busy) begin
        errors++; $display("FAIL rand_out n=%0d stall=%b lu=%b busy=%b required %b/%b/%b",
                           n, stall, load_use_o, mc_busy_o, exp_stall, exp_lu, exp_busy);
      end
      checks++; if (perf_stall_cyc_o !== ep_pc || perf_load_use_o !== ep_pl) begin
        errors++; $display("FAIL rand_perf n=%0d got %0d/%0d required %0d/%0d",
                           n, perf_stall_cyc_o, perf_load_use_o, ep_pc, ep_pl);
      end
      tick();
    end
    rst = 0;
    clear_inputs();
  endtask

  initial begin
    rem = 0; m_pc = 0; m_pl = 0;
    clear_inputs();
    rst = 1;
    #1;
    test_reset();
    test_mc_hold();
    test_load_use();
    test_ex_priority();
    test_len_edges();
    test_reset_mid_hold();
    test_perf();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
